// File: rtl/bitmap_encoder_if.sv
// Bitmap-in / index-beat-out handshake bundle for bitmap_encoder.
// Handshakes use valid/ready: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface bitmap_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        out_none;
  logic [4:0]  out_count;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none, out_count
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none, out_count
  );
endinterface

// File: rtl/bitmap_encoder.sv
// Serializes a 16-bit bitmap into one 4-bit index beat per set bit (inverse of a 4-to-16 decoder).
// LSB_FIRST selects whether the lowest or highest set bit is reported first.
module bitmap_encoder #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  bitmap_encoder_if.slave  bus,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  scan_idx;
  logic        single_or_zero;

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  // The last assignment in the loop wins, so loop direction picks the scan order.
  always_comb begin
    scan_idx = '0;
    if (LSB_FIRST) begin
      for (int i = 15; i >= 0; i--) if (pending_q[i]) scan_idx = 4'(i);
    end else begin
      for (int i = 0; i < 16; i++) if (pending_q[i]) scan_idx = 4'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a one-hot or empty pending word.
  assign single_or_zero = ((pending_q & (pending_q - 16'd1)) == 16'd0);

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    count_d       = count_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.out_none  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          pending_d = bus.in_vec;
          count_d   = popcount(bus.in_vec);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = scan_idx;
        bus.out_none  = (pending_q == 16'd0);
        bus.out_last  = single_or_zero;
        if (bus.out_ready) begin
          if (single_or_zero) begin
            pending_d = '0;
            state_d   = IDLE;
          end else begin
            pending_d = pending_q & ~(16'd1 << scan_idx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign bus.out_count = count_q;
  assign dbg_state     = (state_q == EMIT);

endmodule
